reel_lfsr_bank: RTL
===================

// Module: reel_lfsr_bank
// PURPOSE
//  Pseudo-random source for the slot machine core's three reels. Drives lfsr_out0..2 into the core's lfsr_in0..2
//  and obeys the core's enable0..2: a reel advances while enabled and freezes when its enable drops.
//  Also latches the three final symbols, classifies the outcome and emits a one-cycle result_valid strobe.
// PARAMETERS
//  TICK_DIV    24'h0F4240  tick period minus 1; LFSRs step once per TICK_DIV+1 clocks
//  SEED0       4'h1        reset value of LFSR 0 (4'h0 is replaced by 4'h1)
//  SEED1       4'h5        reset value of LFSR 1 (same zero rule)
//  SEED2       4'h9        reset value of LFSR 2 (same zero rule)
//  ENTROPY_EN  1           1: XOR the entropy counter into an LFSR on its enable rising edge; 0: no mixing
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-low reset
//  enable0       in   1  reel 0 run request (from core)
//  enable1       in   1  reel 1 run request
//  enable2       in   1  reel 2 run request
//  lfsr_out0     out  4  LFSR 0 state (core uses [2:0])
//  lfsr_out1     out  4  LFSR 1 state
//  lfsr_out2     out  4  LFSR 2 state
//  result_sym    out  9  final symbols {sym2,sym1,sym0}, 3 bits each
//  win_code      out  2  2'b11 three equal; 2'b10 exactly two equal; 2'b00 none
//  result_valid  out  1  one-cycle strobe; result_sym and win_code are valid from this cycle on
// BEHAVIOUR
//  Reset (async, reset==0):
//   - lfsr_outN = SEEDN (4'h1 if the seed is 0)
//   - result_sym = 0, win_code = 0, result_valid = 0
//   - tick counter, entropy counter, enable_d and stopped flags = 0; FSM = IDLE
//  Tick:
//   - tick_cnt counts 0..TICK_DIV, then wraps to 0; tick = (tick_cnt == TICK_DIV)
//  LFSR step:
//   - on tick with enableN==1: lfsrN <= {lfsrN[2:0], lfsrN[3]^lfsrN[0]}
//   - maximal length: 15 states, never 0; held otherwise
//  Edges:
//   - enable_d registered every clock; rise = en & ~en_d; fall = ~en & en_d
//  Entropy:
//   - 4-bit counter, +1 every clock, wraps
//   - on riseN with ENTROPY_EN=1: lfsrN <= lfsrN ^ entropy; a zero result loads 4'h1 instead
//   - rise has priority over a coincident tick step
//  Symbol latch:
//   - on fallN: symN <= lfsrN[2:0] (value before any same-cycle step); stoppedN <= 1
//  FSM:
//   - IDLE: any riseN -> SPIN; clear stopped[2:0]; stopped flags still set by falls
//   - SPIN: riseN clears stoppedN (re-spin); stopped==3'b111 -> SETTLE, load settle_cnt = TICK_DIV
//   - SETTLE: settle_cnt decrements to 0, then -> REPORT (TICK_DIV+1 clocks, so the core samples the frozen
//     values); any riseN -> SPIN and clears that reel's stopped flag
//   - REPORT: one cycle; result_valid=1; result_sym/win_code updated from symN; -> IDLE
//  Outputs:
//   - result_sym and win_code hold until the next REPORT
//   - result_valid is 0 in all states except REPORT
//  win_code:
//   - 11 if s0==s1==s2
//   - 10 if exactly one pair is equal
//   - else 00
//  Reset asserted mid-spin or mid-settle: immediate return to reset values, no strobe.
// TESTING
//  T1 ENTROPY_EN=0, TICK_DIV=3, SEED0=1, enable0=1: lfsr_out0 = 3,7,F,E at 4-clock intervals; reels 1/2 hold 5/9
//  T2 Hold enable0 high 15 ticks: lfsr_out0 returns to 1 and is never 0; enable0 low: value frozen for 100 clks
//  T3 Enables rise together, fall with lfsr_out=2,A,A: TICK_DIV+1 clks after the last fall,
//     result_valid for 1 clk, result_sym={3'd2,3'd2,3'd2}, win_code=11
//  T4 Final symbols 3,5,3 -> win_code=10; symbols 1,2,4 -> 00; each strobe is exactly 1 clk
//  T5 Re-raise enable1 during SETTLE -> no strobe; FSM back to SPIN; strobe only after enable1 falls again
//  T6 reset=0 mid-SPIN and mid-SETTLE: outputs return to seeds/zeros at once, no result_valid;
//     ENTROPY_EN=1 with entropy==lfsr: loads 4'h1

Source files
------------

// File: rtl/reel_lfsr_bank.sv
// reel_lfsr_bank: three reel LFSRs with entropy mixing, final-symbol latch and win classification
module reel_lfsr_bank #(
  parameter logic [23:0] TICK_DIV   = 24'h0F4240,
  parameter logic [3:0]  SEED0      = 4'h1,
  parameter logic [3:0]  SEED1      = 4'h5,
  parameter logic [3:0]  SEED2      = 4'h9,
  parameter bit          ENTROPY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable0,
  input  logic       enable1,
  input  logic       enable2,
  output logic [3:0] lfsr_out0,
  output logic [3:0] lfsr_out1,
  output logic [3:0] lfsr_out2,
  output logic [8:0] result_sym,
  output logic [1:0] win_code,
  output logic       result_valid
);
  typedef enum logic [1:0] {IDLE, SPIN, SETTLE, REPORT} state_t;
  localparam logic [11:0] SEEDS = {SEED2 == 4'h0 ? 4'h1 : SEED2,
                                   SEED1 == 4'h0 ? 4'h1 : SEED1,
                                   SEED0 == 4'h0 ? 4'h1 : SEED0};
  state_t state, nxt;
  logic [23:0] tick_cnt, settle_cnt;
  logic [3:0] ent;
  logic [2:0] en, en_d, rise, fall, stopped, clr;
  logic [2:0][3:0] lfsr, mix;
  logic [2:0][2:0] sym;
  logic [1:0] win;
  logic tick;
  assign en = {enable2, enable1, enable0};
  assign rise = en & ~en_d;
  assign fall = ~en & en_d;
  assign tick = tick_cnt == TICK_DIV;
  assign {lfsr_out2, lfsr_out1, lfsr_out0} = lfsr;
  // a new spin from IDLE forgets every old stop; a re-spin only forgets its own reel
  assign clr = state == IDLE ? {3{|rise}} : (state == SPIN || state == SETTLE) ? rise : 3'b000;
  always_comb begin
    for (int i = 0; i < 3; i++) mix[i] = (lfsr[i] ^ ent) == 4'h0 ? 4'h1 : lfsr[i] ^ ent;
  end
  always_comb begin
    win = (sym[0] == sym[1] && sym[1] == sym[2]) ? 2'b11 :
          (sym[0] == sym[1] || sym[1] == sym[2] || sym[0] == sym[2]) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |rise ? SPIN : IDLE;
      SPIN:    nxt = (&stopped && !(|rise)) ? SETTLE : SPIN;
      SETTLE:  nxt = |rise ? SPIN : settle_cnt == 24'd0 ? REPORT : SETTLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    result_valid = state == REPORT;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt   <= '0;
      settle_cnt <= '0;
      ent        <= '0;
      en_d       <= '0;
      stopped    <= '0;
      lfsr       <= SEEDS;
      sym        <= '0;
      result_sym <= '0;
      win_code   <= '0;
    end else begin
      tick_cnt   <= tick ? 24'd0 : tick_cnt + 24'd1;
      ent        <= ent + 4'd1;
      en_d       <= en;
      stopped    <= (stopped & ~clr) | fall;
      settle_cnt <= state == SETTLE ? settle_cnt - 24'd1 : TICK_DIV;
      for (int i = 0; i < 3; i++) begin
        if (ENTROPY_EN && rise[i]) lfsr[i] <= mix[i];
        else if (tick && en[i]) lfsr[i] <= {lfsr[i][2:0], lfsr[i][3] ^ lfsr[i][0]};
        if (fall[i]) sym[i] <= lfsr[i][2:0];
      end
      if (nxt == REPORT) begin
        result_sym <= sym;
        win_code   <= win;
      end
    end
  end
endmodule
